// File: rtl/bps_pkg.sv
// Shared defaults and named step constants for the programmable bit-rate generator.
// Step values are round(baud * mult / f_clk * 2^32) for a 32-bit accumulator.
package bps_pkg;

    localparam int ACC_W_DEF = 32;
    localparam int OVS_DEF   = 16;
    localparam int CNT_W     = 7;

    typedef logic [CNT_W-1:0] ovs_cnt_t;

    localparam logic [31:0] STEP_50M_9600_X1     = 32'd824634;
    localparam logic [31:0] STEP_50M_9600_X16    = 32'd13194140;
    localparam logic [31:0] STEP_50M_115200_X1   = 32'd9895605;
    localparam logic [31:0] STEP_50M_115200_X16  = 32'd158329674;
    localparam logic [31:0] STEP_50M_256000_X1   = 32'd21990233;
    localparam logic [31:0] STEP_50M_256000_X16  = 32'd351843721;
    localparam logic [31:0] STEP_100M_9600_X1    = 32'd412317;
    localparam logic [31:0] STEP_100M_9600_X16   = 32'd6597070;
    localparam logic [31:0] STEP_100M_115200_X1  = 32'd4947802;
    localparam logic [31:0] STEP_100M_115200_X16 = 32'd79164837;
    localparam logic [31:0] STEP_100M_256000_X1  = 32'd10995116;
    localparam logic [31:0] STEP_100M_256000_X16 = 32'd175921860;

    localparam logic [47:0] STEP_INIT_DEF = {16'd0, STEP_50M_115200_X16};

    function automatic ovs_cnt_t ovs_inc(input ovs_cnt_t cnt, input ovs_cnt_t last);
        return (cnt == last) ? ovs_cnt_t'(0) : cnt + ovs_cnt_t'(1);
    endfunction

endpackage

// File: rtl/bps_gen_prog_if.sv
// Control/status bundle of the bit-rate generator; master drives controls, slave is the generator.
interface bps_gen_prog_if
    import bps_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
);
    logic             En_Sig;
    logic             SYNC;
    logic             STEP_WR;
    logic [ACC_W-1:0] STEP_IN;
    logic             STEP_PEND;
    logic             OVS_CLKen;
    logic             MID_CLKen;
    logic             BPS_CLKen;
    logic             BPS_CLK;

    modport master (
        output En_Sig, SYNC, STEP_WR, STEP_IN,
        input  STEP_PEND, OVS_CLKen, MID_CLKen, BPS_CLKen, BPS_CLK
    );

    modport slave (
        input  En_Sig, SYNC, STEP_WR, STEP_IN,
        output STEP_PEND, OVS_CLKen, MID_CLKen, BPS_CLKen, BPS_CLK
    );
endinterface

// File: rtl/bps_phase_acc.sv
// Phase accumulator with registered carry (tick); also exposes the same-cycle carry
// and the accumulator MSB (current and next) for the downstream pulse logic.
module bps_phase_acc
    import bps_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [ACC_W-1:0] step,
    output logic             tick,
    output logic             carry,
    output logic             msb,
    output logic             msb_next
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             tick_q, tick_d;
    logic [ACC_W:0]   sum_s;

    // Next accumulator value; a disabled cycle holds the phase and emits no tick.
    always_comb begin
        sum_s  = {1'b0, acc_q} + {1'b0, step};
        acc_d  = acc_q;
        tick_d = 1'b0;
        if (clear) begin
            acc_d  = {ACC_W{1'b0}};
            tick_d = 1'b0;
        end else if (enable) begin
            acc_d  = sum_s[ACC_W-1:0];
            tick_d = sum_s[ACC_W];
        end else begin
            acc_d  = acc_q;
            tick_d = 1'b0;
        end
    end

    // Accumulator and tick registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q  <= {ACC_W{1'b0}};
            tick_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            tick_q <= tick_d;
        end
    end

    assign tick     = tick_q;
    assign carry    = enable && !clear && sum_s[ACC_W];
    assign msb      = acc_q[ACC_W-1];
    assign msb_next = acc_d[ACC_W-1];

endmodule

// File: rtl/bps_gen_prog.sv
// Programmable DDS bit-rate generator with shadowed step and phase restart.
// Define BPS_OVS_EN for the oversampling divider; otherwise the carry marks bit boundaries.
module bps_gen_prog
    import bps_pkg::*;
#(
    parameter int          ACC_W     = ACC_W_DEF,
    parameter int          OVS       = OVS_DEF,
    parameter logic [47:0] STEP_INIT = STEP_INIT_DEF
) (
    input  logic          CLOCK,
    input  logic          RST,
    bps_gen_prog_if.slave bus
);

    logic [ACC_W-1:0] step_q, step_d;
    logic [ACC_W-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             tick_s, carry_s, msb_s, msb_next_s, wrap_s;

    bps_phase_acc #(.ACC_W(ACC_W)) u_acc (
        .clock    (CLOCK),
        .reset    (RST),
        .enable   (bus.En_Sig),
        .clear    (bus.SYNC),
        .step     (step_q),
        .tick     (tick_s),
        .carry    (carry_s),
        .msb      (msb_s),
        .msb_next (msb_next_s)
    );

    // Shadow step: applied on a bit boundary, while idle, or immediately on SYNC.
    always_comb begin
        step_d   = step_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        if (bus.SYNC) begin
            step_d   = bus.STEP_WR ? bus.STEP_IN : (pend_q ? shadow_q : step_q);
            shadow_d = bus.STEP_WR ? bus.STEP_IN : shadow_q;
            pend_d   = 1'b0;
        end else begin
            if (pend_q && (wrap_s || !bus.En_Sig)) begin
                step_d = shadow_q;
                pend_d = 1'b0;
            end else begin
                step_d = step_q;
                pend_d = pend_q;
            end
            if (bus.STEP_WR) begin
                shadow_d = bus.STEP_IN;
                pend_d   = 1'b1;
            end else begin
                shadow_d = shadow_q;
            end
        end
    end

    // Step, shadow and pending-flag registers.
    always_ff @(posedge CLOCK) begin
        if (RST) begin
            step_q   <= STEP_INIT[ACC_W-1:0];
            shadow_q <= {ACC_W{1'b0}};
            pend_q   <= 1'b0;
        end else begin
            step_q   <= step_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
        end
    end

    assign bus.STEP_PEND = pend_q;

`ifdef BPS_OVS_EN
    localparam ovs_cnt_t OVS_M1  = ovs_cnt_t'(OVS - 1);
    localparam ovs_cnt_t HALF    = ovs_cnt_t'(OVS / 2);
    localparam ovs_cnt_t HALF_M1 = ovs_cnt_t'(OVS / 2 - 1);

    ovs_cnt_t cnt_q, cnt_d;
    logic     mid_q, mid_d, bps_q, bps_d, bclk_q, bclk_d;

    assign wrap_s = carry_s && (cnt_q == OVS_M1);

    // Oversample counter; pulses are registered in the same cycle as the tick.
    always_comb begin
        cnt_d  = cnt_q;
        mid_d  = 1'b0;
        bps_d  = 1'b0;
        bclk_d = bclk_q;
        if (bus.SYNC) begin
            cnt_d  = ovs_cnt_t'(0);
            bclk_d = 1'b0;
        end else if (carry_s) begin
            cnt_d  = ovs_inc(cnt_q, OVS_M1);
            bps_d  = (cnt_q == OVS_M1);
            mid_d  = (cnt_q == HALF_M1);
            bclk_d = (cnt_d >= HALF);
        end else begin
            cnt_d  = cnt_q;
            bclk_d = bclk_q;
        end
    end

    // Oversample counter and output registers.
    always_ff @(posedge CLOCK) begin
        if (RST) begin
            cnt_q  <= ovs_cnt_t'(0);
            mid_q  <= 1'b0;
            bps_q  <= 1'b0;
            bclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mid_q  <= mid_d;
            bps_q  <= bps_d;
            bclk_q <= bclk_d;
        end
    end

    assign bus.OVS_CLKen = tick_s;
    assign bus.MID_CLKen = mid_q;
    assign bus.BPS_CLKen = bps_q;
    assign bus.BPS_CLK   = bclk_q;
`else
    logic mid_q, mid_d;

    assign wrap_s = carry_s;

    // Mid-bit pulse marks the accumulator MSB rising.
    always_comb begin
        mid_d = 1'b0;
        if (bus.SYNC) begin
            mid_d = 1'b0;
        end else begin
            mid_d = msb_next_s && !msb_s;
        end
    end

    // Mid-bit pulse register.
    always_ff @(posedge CLOCK) begin
        if (RST) begin
            mid_q <= 1'b0;
        end else begin
            mid_q <= mid_d;
        end
    end

    assign bus.OVS_CLKen = 1'b0;
    assign bus.MID_CLKen = mid_q;
    assign bus.BPS_CLKen = tick_s;
    assign bus.BPS_CLK   = msb_s;
`endif

endmodule

// File: tb/tb_bps_gen_prog.sv
// Bench for bps_gen_prog (ACC_W=8, OVS=16): directed timing checks plus random
// stimulus compared each cycle against an arithmetic reference model.
module tb_bps_gen_prog;

    localparam int          ACC_W     = 8;
    localparam int          OVS       = 16;
    localparam int          MOD       = 1 << ACC_W;
    localparam logic [47:0] STEP_INIT = 48'd16;
`ifdef BPS_OVS_EN
    localparam int P16 = 256;
    localparam int P32 = 128;
`else
    localparam int P16 = 16;
    localparam int P32 = 8;
`endif

    logic CLOCK = 1'b0;
    logic RST   = 1'b1;

    bps_gen_prog_if #(.ACC_W(ACC_W)) bus ();

    bps_gen_prog #(.ACC_W(ACC_W), .OVS(OVS), .STEP_INIT(STEP_INIT)) dut (
        .CLOCK (CLOCK),
        .RST   (RST),
        .bus   (bus)
    );

    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pulse_cnt = 0;
    int ovs_seen  = 0;
    int high_cnt  = 0;

    // reference model state
    int m_acc, m_cnt, m_step, m_shadow;
    bit m_pend, m_ovs, m_mid, m_bps, m_bclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step();
        int  sum, nacc, in_v;
        bit  apply, carry;
        in_v = int'(bus.STEP_IN);
        apply = 1'b0;
        if (RST) begin
            m_acc = 0; m_cnt = 0; m_step = int'(STEP_INIT[ACC_W-1:0]); m_shadow = 0;
            m_pend = 0; m_ovs = 0; m_mid = 0; m_bps = 0; m_bclk = 0;
        end else if (bus.SYNC) begin
            m_step   = bus.STEP_WR ? in_v : (m_pend ? m_shadow : m_step);
            m_shadow = bus.STEP_WR ? in_v : m_shadow;
            m_pend = 0; m_acc = 0; m_cnt = 0; m_bclk = 0;
            m_ovs = 0; m_mid = 0; m_bps = 0;
        end else begin
            if (bus.En_Sig) begin
                sum   = m_acc + m_step;
                nacc  = sum % MOD;
                carry = (sum >= MOD);
`ifdef BPS_OVS_EN
                m_ovs = carry;
                m_bps = carry && (m_cnt == OVS - 1);
                m_mid = carry && (m_cnt == OVS / 2 - 1);
                if (carry) m_cnt = (m_cnt + 1) % OVS;
                m_bclk = (m_cnt >= OVS / 2);
`else
                m_ovs  = 0;
                m_bps  = carry;
                m_mid  = (m_acc < MOD / 2) && (nacc >= MOD / 2);
                m_bclk = (nacc >= MOD / 2);
`endif
                m_acc = nacc;
                apply = m_pend && m_bps;
            end else begin
                m_ovs = 0; m_mid = 0; m_bps = 0;
                apply = m_pend;
            end
            if (apply) begin
                m_step = m_shadow;
                m_pend = 0;
            end
            if (bus.STEP_WR) begin
                m_shadow = in_v;
                m_pend   = 1;
            end
        end
    endtask

    task automatic clk_cycle();
        @(posedge CLOCK);
        model_step();
        cyc++;
        #1;
        chk("outs", {59'd0, bus.STEP_PEND, bus.OVS_CLKen, bus.MID_CLKen, bus.BPS_CLKen, bus.BPS_CLK},
                    {59'd0, m_pend, m_ovs, m_mid, m_bps, m_bclk});
        if (bus.OVS_CLKen || bus.MID_CLKen || bus.BPS_CLKen) pulse_cnt++;
        if (bus.OVS_CLKen) ovs_seen++;
        if (bus.BPS_CLK) high_cnt++;
    endtask

    // sel 0 waits for BPS_CLKen, sel 1 for MID_CLKen
    task automatic wait_pulse(input string tag, input int sel, input int budget, output int at);
        bit found;
        int n;
        found = 1'b0;
        n = 0;
        while (!found && n < budget) begin
            clk_cycle();
            n++;
            if ((sel == 0 && bus.BPS_CLKen === 1'b1) || (sel == 1 && bus.MID_CLKen === 1'b1))
                found = 1'b1;
        end
        at = cyc;
        chk({"wait_", tag}, {63'd0, found}, 64'd1);
    endtask

    initial begin
        int t0, t1, t2, t3, t4, t5, tm, ts;
        bus.En_Sig  = 1'b0;
        bus.SYNC    = 1'b0;
        bus.STEP_WR = 1'b0;
        bus.STEP_IN = 8'd0;
        RST = 1'b1;
        repeat (2) clk_cycle();
        chk("rst_outs", {59'd0, bus.STEP_PEND, bus.OVS_CLKen, bus.MID_CLKen, bus.BPS_CLKen, bus.BPS_CLK}, 64'd0);

        // reset step: period, mid offset, duty
        RST = 1'b0;
        bus.En_Sig = 1'b1;
        ovs_seen = 0;
        wait_pulse("bps0", 0, 4 * P16, t0);
        high_cnt = 0;
        wait_pulse("mid0", 1, 2 * P16, tm);
        wait_pulse("bps1", 0, 2 * P16, t1);
        chk("period16", 64'(t1 - t0), 64'(P16));
        chk("mid_off16", 64'(tm - t0), 64'(P16 / 2));
        chk("duty_high", 64'(high_cnt), 64'(P16 / 2));
`ifndef BPS_OVS_EN
        chk("ovs_zero", 64'(ovs_seen), 64'd0);
`endif

        // enable gap of 50 cycles mid-bit
        repeat (P16 / 4) clk_cycle();
        pulse_cnt = 0;
        bus.En_Sig = 1'b0;
        repeat (50) clk_cycle();
        chk("gap_quiet", 64'(pulse_cnt), 64'd0);
        bus.En_Sig = 1'b1;
        wait_pulse("bps_gap", 0, 2 * P16 + 50, t2);
        chk("gap_delay", 64'(t2 - t1), 64'(P16 + 50));

        // phase restart around oversample count 11
        repeat ((11 * P16) / 16 + 3) clk_cycle();
        bus.SYNC = 1'b1;
        clk_cycle();
        ts = cyc;
        bus.SYNC = 1'b0;
        chk("sync_quiet", {61'd0, bus.OVS_CLKen, bus.MID_CLKen, bus.BPS_CLKen}, 64'd0);
        wait_pulse("mid_sync", 1, 2 * P16, tm);
        chk("sync_mid", 64'(tm - ts), 64'(P16 / 2));

        // step write around oversample count 5, applied at next bit boundary
        wait_pulse("bps3", 0, 2 * P16, t3);
        repeat ((5 * P16) / 16 + 2) clk_cycle();
        bus.STEP_IN = 8'd32;
        bus.STEP_WR = 1'b1;
        clk_cycle();
        bus.STEP_WR = 1'b0;
        chk("pend_set", {63'd0, bus.STEP_PEND}, 64'd1);
        wait_pulse("bps4", 0, 2 * P16, t4);
        chk("pend_clr", {63'd0, bus.STEP_PEND}, 64'd0);
        wait_pulse("bps5", 0, 2 * P16, t5);
        chk("period32", 64'(t5 - t4), 64'(P32));
        wait_pulse("mid32", 1, 2 * P32, tm);
        chk("mid_off32", 64'(tm - t5), 64'(P32 / 2));

        // reset with a pending step discards it and restores the reset step
        repeat (2) clk_cycle();
        bus.STEP_IN = 8'd32;
        bus.STEP_WR = 1'b1;
        clk_cycle();
        bus.STEP_WR = 1'b0;
        RST = 1'b1;
        clk_cycle();
        RST = 1'b0;
        chk("rst_pend", {63'd0, bus.STEP_PEND}, 64'd0);
        wait_pulse("bps_r0", 0, 2 * P16, t0);
        wait_pulse("bps_r1", 0, 2 * P16, t1);
        chk("rst_period", 64'(t1 - t0), 64'(P16));

        // random stimulus against the reference model
        for (int i = 0; i < 8000; i++) begin
            RST         = ($urandom_range(0, 999) == 0);
            bus.En_Sig  = ($urandom_range(0, 9) != 0);
            bus.SYNC    = ($urandom_range(0, 299) == 0);
            bus.STEP_WR = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 3))
                0:       bus.STEP_IN = 8'd16;
                1:       bus.STEP_IN = 8'd32;
                2:       bus.STEP_IN = 8'($urandom_range(0, 255));
                default: bus.STEP_IN = 8'd64;
            endcase
            clk_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
